xtest_stim_gen: RTL and testbench

Stimulus generator that drives the 4-bit a_ch channel into the xtest datapath. It is the driving end of the interface the xtest assertion checker observes. It produces a programmable burst of beats (constant, incrementing, LFSR or walking-one) under a valid/ready handshake. After reset every output is a known value, so no X can enter reg_out/act_t from the stimulus side.

---
 rtl/xtest_stim_gen_if.sv | 10 +
 rtl/xtest_stim_gen.sv | 98 +++++++++
 tb/tb_xtest_stim_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/xtest_stim_gen_if.sv
// xtest_stim_gen_if: a_ch beat channel with valid/ready handshake
interface xtest_stim_gen_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a_ch;
    logic             a_ch_valid;
    logic             ready;
    modport master (output a_ch, output a_ch_valid, input ready);
    modport slave  (input a_ch, input a_ch_valid, output ready);
endinterface

// File: rtl/xtest_stim_gen.sv
// xtest_stim_gen: programmable burst generator driving the xtest a_ch channel
module xtest_stim_gen #(
    parameter int          WIDTH = 4,
    parameter int          LEN_W = 8,
    parameter int unsigned SEED  = 4'h9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] init,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] beat_cnt,
    xtest_stim_gen_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
    state_t           state_q;
    logic [1:0]       mode_q;
    logic [LEN_W-1:0] len_q;
    logic [WIDTH-1:0] a_ch_q;
    logic [WIDTH-1:0] a_ch_d;
    logic [WIDTH-1:0] init_eff;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             xfer;
    // next beat value for the captured mode, and the zero-substituted first beat
    always_comb begin
        a_ch_d   = mode_q == 2'd0 ? a_ch_q :
                   mode_q == 2'd1 ? a_ch_q + 1'b1 :
                   mode_q == 2'd2 ? {a_ch_q[WIDTH-2:0], a_ch_q[WIDTH-1] ^ a_ch_q[WIDTH-2]} :
                                    {a_ch_q[WIDTH-2:0], a_ch_q[WIDTH-1]};
        init_eff = init != '0   ? init :
                   mode == 2'd2 ? SEED_W :
                   mode == 2'd3 ? WIDTH'(1) : init;
        cnt_d    = cnt_q + LEN_W'(1);
        xfer     = valid_q & bus.ready;
    end
    // burst FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            len_q   <= '0;
            a_ch_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            mode_q  <= mode;
                            len_q   <= len;
                            a_ch_q  <= init_eff;
                            valid_q <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        a_ch_q <= a_ch_d;
                        cnt_q  <= cnt_d;
                        if (cnt_d == len_q) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign bus.a_ch       = a_ch_q;
    assign bus.a_ch_valid = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign beat_cnt       = cnt_q;
endmodule

// File: tb/tb_xtest_stim_gen.sv
// tb_xtest_stim_gen: directed-vector bench for the xtest stimulus generator
module tb_xtest_stim_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] len = 8'd0;
    logic [3:0] init = 4'd0;
    logic       busy;
    logic       done;
    logic [7:0] beat_cnt;
    int         vecs = 0;
    int         errs = 0;

    xtest_stim_gen_if #(.WIDTH(4)) bus ();

    xtest_stim_gen #(.WIDTH(4), .LEN_W(8), .SEED(4'h9)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .len      (len),
        .init     (init),
        .busy     (busy),
        .done     (done),
        .beat_cnt (beat_cnt),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // one burst; beats packs expected beat k at [4k+:4], rdy bit c is ready in stream cycle c
    task automatic burst(input string tag, input logic [1:0] m, input logic [3:0] ini,
                         input logic [7:0] l, input logic [15:0] beats,
                         input logic [15:0] rdy, input logic [3:0] fin);
        int k = 0;
        int c = 0;
        mode = m; init = ini; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k < int'(l) && c < 16) begin
            chk({tag, "_valid"}, 32'(bus.a_ch_valid), 32'd1);
            chk({tag, "_beat"}, 32'(bus.a_ch), 32'(beats[4*k +: 4]));
            chk({tag, "_cnt"}, 32'(beat_cnt), 32'(k));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            bus.ready = rdy[c];
            @(negedge clk);
            if (rdy[c]) k++;
            c++;
        end
        chk({tag, "_timeout"}, 32'(k), 32'(l));
        chk({tag, "_done"}, 32'({done, busy, bus.a_ch_valid}), 32'b110);
        chk({tag, "_fin"}, 32'(bus.a_ch), 32'(fin));
        chk({tag, "_endcnt"}, 32'(beat_cnt), 32'(l));
        bus.ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, 32'({done, busy, bus.a_ch_valid}), 32'b000);
        chk({tag, "_keepcnt"}, 32'(beat_cnt), 32'(l));
    endtask

    initial begin
        bus.ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // reset state held while idle
        for (int i = 0; i < 5; i++) begin
            chk("reset_idle", 32'({bus.a_ch, bus.a_ch_valid, busy, done, beat_cnt}), 32'd0);
            @(negedge clk);
        end
        // increment with wrap, constant ready
        burst("inc", 2'd1, 4'hE, 8'd4, 16'h10FE, 16'h000F, 4'h2);
        // LFSR with seed substitution
        burst("lfsr", 2'd2, 4'h0, 8'd3, 16'h0639, 16'h0007, 4'hD);
        // walking one with ready stalls 1,0,0,1,1
        burst("walk", 2'd3, 4'h8, 8'd3, 16'h0218, 16'h0019, 4'h4);
        // walking one with zero init substituted by 1
        burst("walk0", 2'd3, 4'h0, 8'd2, 16'h0021, 16'h0003, 4'h4);
        // zero-length burst goes straight to DONE
        len = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", 32'({done, busy, bus.a_ch_valid}), 32'b110);
        chk("len0_cnt", 32'(beat_cnt), 32'd0);
        chk("len0_ach", 32'(bus.a_ch), 32'h4);
        @(negedge clk);
        chk("len0_idle", 32'({done, busy, bus.a_ch_valid}), 32'b000);
        // start held during RUN with new fields is ignored
        mode = 2'd0; init = 4'h5; len = 8'd2; start = 1'b1; bus.ready = 1'b0;
        @(negedge clk);
        mode = 2'd1; init = 4'hA; len = 8'd7;
        chk("ign_first", 32'({bus.a_ch, bus.a_ch_valid}), 32'({4'h5, 1'b1}));
        @(negedge clk);
        chk("ign_stall", 32'({bus.a_ch, beat_cnt}), 32'({4'h5, 8'd0}));
        bus.ready = 1'b1;
        @(negedge clk);
        chk("ign_beat2", 32'({bus.a_ch, bus.a_ch_valid, beat_cnt}), 32'({4'h5, 1'b1, 8'd1}));
        @(negedge clk);
        chk("ign_done", 32'({done, bus.a_ch_valid, beat_cnt, bus.a_ch}), 32'({1'b1, 1'b0, 8'd2, 4'h5}));
        start = 1'b0; bus.ready = 1'b0;
        @(negedge clk);
        chk("ign_idle", 32'({done, busy, beat_cnt}), 32'({1'b0, 1'b0, 8'd2}));
        // reset after beat 2 of a 5-beat burst
        mode = 2'd1; init = 4'h3; len = 8'd5; start = 1'b1; bus.ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_b0", 32'(bus.a_ch), 32'h3);
        @(negedge clk);
        chk("rst_b1", 32'({bus.a_ch, beat_cnt}), 32'({4'h4, 8'd1}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.ready = 1'b0;
        chk("rst_mid", 32'({bus.a_ch, bus.a_ch_valid, busy, done, beat_cnt}), 32'd0);
        @(negedge clk);
        chk("rst_nodone", 32'({bus.a_ch, bus.a_ch_valid, busy, done, beat_cnt}), 32'd0);
        burst("after_rst", 2'd1, 4'h7, 8'd2, 16'h0087, 16'h0003, 4'h9);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
